// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single port of the instr/data memory between the multicycle core
//   (m0) and the program loader/debug port (m1).
//   - Ownership is held in a registered FSM (IDLE/OWN0/OWN1). A side is granted
//     only while its FSM state owns the port and it keeps requesting.
//   - An owner that keeps requesting is forced to hand over after MAX_HOLD
//     consecutive grants if the other side is waiting.
//   - core_stall tells the core's control unit to freeze while m0 waits.
// Optional build macro:
//   MEM_ARB_ROUND_ROBIN_EN - on a simultaneous request from IDLE, the side that
//   did not own the port last wins. Without it, m0 always wins that tie.
// Ports:
//   clk, rstb                  clock (rising edge), asynchronous active-low reset
//   mX_req/mX_we/mX_addr/      requester X access request, write enable, address,
//   mX_wdata                   write data (X = 0 core, 1 loader)
//   mX_gnt                     requester X owns the port this cycle
//   mX_rvalid/mX_rdata         read response, one cycle after a granted read
//   mem_wr_ena/mem_addr/       memory port 0 controls
//   mem_din/mem_dout           (dout is a synchronous read, valid one cycle later)
//   core_stall                 m0 requests but is not granted
module mem_port_arbiter #(
  parameter int N        = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         m0_req,
  input  logic         m0_we,
  input  logic [N-1:0] m0_addr,
  input  logic [N-1:0] m0_wdata,
  output logic         m0_gnt,
  output logic         m0_rvalid,
  output logic [N-1:0] m0_rdata,
  input  logic         m1_req,
  input  logic         m1_we,
  input  logic [N-1:0] m1_addr,
  input  logic [N-1:0] m1_wdata,
  output logic         m1_gnt,
  output logic         m1_rvalid,
  output logic [N-1:0] m1_rdata,
  output logic         mem_wr_ena,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_din,
  input  logic [N-1:0] mem_dout,
  output logic         core_stall
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] hold_nxt;
  logic [N-1:0]  addr_q;
  logic [N-1:0]  din_q;
  logic          rvalid0_q;
  logic          rvalid1_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic          last_owner;
  logic          last_nxt;
`endif

  assign m0_gnt     = (state == OWN0) & m0_req;
  assign m1_gnt     = (state == OWN1) & m1_req;
  assign core_stall = m0_req & ~m0_gnt;
  assign m0_rvalid  = rvalid0_q;
  assign m1_rvalid  = rvalid1_q;
  assign m0_rdata   = mem_dout;
  assign m1_rdata   = mem_dout;

  // Next-state and hold-counter logic for port ownership
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        // Nothing is granted in the cycle a request is first seen
        hold_nxt = '0;
        if (m0_req && m1_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          state_nxt = last_owner ? OWN0 : OWN1;
`else
          state_nxt = OWN0;
`endif
        end else if (m0_req) begin
          state_nxt = OWN0;
        end else if (m1_req) begin
          state_nxt = OWN1;
        end else begin
          state_nxt = IDLE;
        end
      end
      OWN0: begin
        if (m0_req) begin
          // >= rather than == so a saturated counter still yields to a late waiter
          if (m1_req && (hold_cnt >= HOLD_LAST)) begin
            state_nxt = OWN1;
            hold_nxt  = '0;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_nxt = hold_cnt + 1'b1;
          end else begin
            hold_nxt = hold_cnt;
          end
        end else if (m1_req) begin
          state_nxt = OWN1;
          hold_nxt  = '0;
        end else begin
          state_nxt = IDLE;
          hold_nxt  = '0;
        end
      end
      OWN1: begin
        if (m1_req) begin
          if (m0_req && (hold_cnt >= HOLD_LAST)) begin
            state_nxt = OWN0;
            hold_nxt  = '0;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_nxt = hold_cnt + 1'b1;
          end else begin
            hold_nxt = hold_cnt;
          end
        end else if (m0_req) begin
          state_nxt = OWN0;
          hold_nxt  = '0;
        end else begin
          state_nxt = IDLE;
          hold_nxt  = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Remember which side entered an OWN state most recently
  always_comb begin
    last_nxt = last_owner;
    if ((state_nxt == OWN0) && (state != OWN0)) begin
      last_nxt = 1'b0;
    end else if ((state_nxt == OWN1) && (state != OWN1)) begin
      last_nxt = 1'b1;
    end else begin
      last_nxt = last_owner;
    end
  end
`endif

  // Memory port mux; without a grant the last driven address/data are held
  always_comb begin
    mem_wr_ena = 1'b0;
    mem_addr   = addr_q;
    mem_din    = din_q;
    if (m0_gnt) begin
      mem_wr_ena = m0_we;
      mem_addr   = m0_addr;
      mem_din    = m0_wdata;
    end else if (m1_gnt) begin
      mem_wr_ena = m1_we;
      mem_addr   = m1_addr;
      mem_din    = m1_wdata;
    end else begin
      mem_wr_ena = 1'b0;
    end
  end

  // State, hold counter, held memory controls and read-valid pipeline
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner <= 1'b1;
`endif
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      addr_q    <= mem_addr;
      din_q     <= mem_din;
      rvalid0_q <= m0_gnt & ~m0_we;
      rvalid1_q <= m1_gnt & ~m1_we;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner <= last_nxt;
`endif
    end
  end

endmodule
